// File: rtl/rst_sequencer.sv
// rst_sequencer: releases NUM_STAGES active-low resets in index order, STAGE_DLY clocks apart,
// with a software re-reset. Define RST_SEQ_WDOG_EN to add a watchdog that forces a re-reset.
module rst_sequencer #(
  parameter int NUM_STAGES = 3,
  parameter int STAGE_DLY  = 16,
  parameter int ASSERT_CYC = 4,
  parameter int WDOG_CYC   = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  soft_rst_req,
  input  logic                  hold,
  input  logic                  wdog_kick,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  all_rdy,
  output logic                  busy,
  output logic                  wdog_fired
);

  localparam int MAX_SA  = (STAGE_DLY > ASSERT_CYC) ? STAGE_DLY : ASSERT_CYC;
  localparam int MAX_CYC = (MAX_SA > WDOG_CYC) ? MAX_SA : WDOG_CYC;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  typedef enum logic [1:0] {
    SEQ    = 2'd0,
    RUN    = 2'd1,
    ASSERT = 2'd2
  } state_e;

  if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_bad_num_stages
    $error("rst_sequencer: NUM_STAGES must be in 1..8");
  end
  if (STAGE_DLY < 1) begin : g_bad_stage_dly
    $error("rst_sequencer: STAGE_DLY must be >= 1");
  end
  if (ASSERT_CYC < 1) begin : g_bad_assert_cyc
    $error("rst_sequencer: ASSERT_CYC must be >= 1");
  end

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  rdy_q, rdy_d;
  logic                  busy_q, busy_d;
  logic                  wdog_to;

`ifdef RST_SEQ_WDOG_EN
  logic [CW-1:0] wdog_q, wdog_d;
  logic          fired_q;

  // Watchdog only runs in RUN; a kick on the timeout cycle still clears it.
  always_comb begin
    wdog_d  = '0;
    wdog_to = 1'b0;
    if (state_q == RUN) begin
      if (wdog_kick) begin
        wdog_d = '0;
      end else if (wdog_q == CW'(WDOG_CYC - 1)) begin
        wdog_to = 1'b1;
      end else begin
        wdog_d = wdog_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q  <= '0;
      fired_q <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      fired_q <= fired_q | wdog_to;
    end
  end

  assign wdog_fired = fired_q;
`else
  logic unused_wdog_kick;
  assign unused_wdog_kick = wdog_kick;
  assign wdog_to          = 1'b0;
  assign wdog_fired       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    rdy_d   = rdy_q;
    busy_d  = busy_q;
    case (state_q)
      SEQ: begin
        // All stages out: report ready one edge later, regardless of hold.
        if (idx_q == 4'(NUM_STAGES)) begin
          state_d = RUN;
          rdy_d   = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (!hold) begin
          if (cnt_q == CW'(STAGE_DLY - 1)) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
              if (idx_q == 4'(i)) stage_d[i] = 1'b1;
            end
            cnt_d = '0;
            idx_d = idx_q + 4'd1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      RUN: begin
        if (soft_rst_req || wdog_to) begin
          state_d = ASSERT;
          stage_d = '0;
          rdy_d   = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      ASSERT: begin
        if (cnt_q == CW'(ASSERT_CYC - 1)) begin
          state_d = SEQ;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = SEQ;
        cnt_d   = '0;
        idx_d   = '0;
        stage_d = '0;
        rdy_d   = 1'b0;
        busy_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEQ;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign stage_rst_n = stage_q;
  assign all_rdy     = rdy_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: two parameterisations driven from shared inputs, compared each
// cycle against a time-based reference model, plus fixed-edge checks of the release schedule.
module tb_rst_sequencer;

  localparam int N1 = 3, D1 = 16, A1 = 4, W1 = 64;
  localparam int N2 = 1, D2 = 1,  A2 = 4, W2 = 32;
`ifdef RST_SEQ_WDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic soft_rst_req = 1'b0;
  logic hold = 1'b0;
  logic wdog_kick = 1'b0;

  logic [N1-1:0] st1;
  logic          rdy1, busy1, fired1;
  logic [N2-1:0] st2;
  logic          rdy2, busy2, fired2;

  int n_chk = 0;
  int n_err = 0;
  int edge_no = 0;

  always #5 clk = ~clk;

  rst_sequencer #(.NUM_STAGES(N1), .STAGE_DLY(D1), .ASSERT_CYC(A1), .WDOG_CYC(W1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .soft_rst_req(soft_rst_req), .hold(hold), .wdog_kick(wdog_kick),
    .stage_rst_n(st1), .all_rdy(rdy1), .busy(busy1), .wdog_fired(fired1)
  );

  rst_sequencer #(.NUM_STAGES(N2), .STAGE_DLY(D2), .ASSERT_CYC(A2), .WDOG_CYC(W2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .soft_rst_req(soft_rst_req), .hold(hold), .wdog_kick(wdog_kick),
    .stage_rst_n(st2), .all_rdy(rdy2), .busy(busy2), .wdog_fired(fired2)
  );

  // Model: mode 0 = sequencing, 1 = running, 2 = holding all stages low.
  // ticks = un-held edges since sequencing began; stage k is out once ticks >= (k+1)*D.
  typedef struct {
    int mode;
    int ticks;
    int acnt;
    int wd;
    bit fired;
  } m_t;

  m_t m1, m2;

  function automatic m_t mreset();
    m_t r;
    r.mode = 0; r.ticks = 0; r.acnt = 0; r.wd = 0; r.fired = 1'b0;
    return r;
  endfunction

  function automatic m_t mstep(m_t m, int n, int d, int a, int w, bit req, bit hld, bit kick);
    m_t r = m;
    bit to = 1'b0;
    case (m.mode)
      0: begin
        if (m.ticks >= n * d) begin
          r.mode = 1;
          r.wd = 0;
        end else if (!hld) begin
          r.ticks = m.ticks + 1;
        end
      end
      1: begin
        if (WD_EN) begin
          if (kick) r.wd = 0;
          else if (m.wd == w - 1) to = 1'b1;
          else r.wd = m.wd + 1;
        end
        if (req || to) begin
          r.mode = 2;
          r.acnt = 0;
          r.fired = m.fired | to;
        end
      end
      default: begin
        r.acnt = m.acnt + 1;
        if (r.acnt == a) begin
          r.mode = 0;
          r.ticks = 0;
        end
      end
    endcase
    return r;
  endfunction

  function automatic logic [7:0] exp_st(m_t m, int n, int d);
    logic [7:0] r = 8'h00;
    for (int k = 0; k < n; k++) begin
      if (m.mode == 1) r[k] = 1'b1;
      else if (m.mode == 0 && m.ticks >= (k + 1) * d) r[k] = 1'b1;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h edge=%0d t=%0t", tag, got, exp, edge_no, $time);
    end
  endtask

  task automatic check_all();
    chk("st1",   32'(st1),    32'(exp_st(m1, N1, D1)));
    chk("rdy1",  32'(rdy1),   32'(m1.mode == 1));
    chk("busy1", 32'(busy1),  32'(m1.mode != 1));
    chk("wdf1",  32'(fired1), 32'(m1.fired));
    chk("st2",   32'(st2),    32'(exp_st(m2, N2, D2)));
    chk("rdy2",  32'(rdy2),   32'(m2.mode == 1));
    chk("busy2", 32'(busy2),  32'(m2.mode != 1));
    chk("wdf2",  32'(fired2), 32'(m2.fired));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m1 = mreset();
      m2 = mreset();
      edge_no = 0;
    end else begin
      m1 = mstep(m1, N1, D1, A1, W1, soft_rst_req, hold, wdog_kick);
      m2 = mstep(m2, N2, D2, A2, W2, soft_rst_req, hold, wdog_kick);
      edge_no++;
    end
    @(negedge clk);
    check_all();
  endtask

  // Pull reset mid-cycle (no clock edge) and check outputs fall at once.
  task automatic async_reset(input int cycles);
    #2 rst_n = 1'b0;
    #1;
    m1 = mreset();
    m2 = mreset();
    edge_no = 0;
    chk("async_st1",  32'(st1),   32'(0));
    chk("async_rdy1", 32'(rdy1),  32'(0));
    chk("async_bsy1", 32'(busy1), 32'(1));
    chk("async_wdf1", 32'(fired1), 32'(0));
    check_all();
    repeat (cycles) tick();
    rst_n = 1'b1;
  endtask

  task automatic pu_checks();
    case (edge_no)
      1:  begin chk("pu2_e1_st", 32'(st2), 32'(1)); chk("pu2_e1_rdy", 32'(rdy2), 32'(0)); end
      2:  chk("pu2_e2_rdy", 32'(rdy2), 32'(1));
      15: chk("pu_e15", 32'(st1), 32'(3'b000));
      16: chk("pu_e16", 32'(st1), 32'(3'b001));
      31: chk("pu_e31", 32'(st1), 32'(3'b001));
      32: chk("pu_e32", 32'(st1), 32'(3'b011));
      48: begin chk("pu_e48", 32'(st1), 32'(3'b111)); chk("pu_e48_rdy", 32'(rdy1), 32'(0)); end
      49: begin chk("pu_e49_rdy", 32'(rdy1), 32'(1)); chk("pu_e49_bsy", 32'(busy1), 32'(0)); end
      default: ;
    endcase
  endtask

  initial begin
    int e0;
    m1 = mreset();
    m2 = mreset();
    #1 rst_n = 1'b0;
    #2 check_all();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // power-up sequence
    repeat (60) begin
      tick();
      pu_checks();
    end

    // hold for edges 20..29
    async_reset(2);
    repeat (65) begin
      hold = (edge_no + 1 >= 20) && (edge_no + 1 <= 29);
      tick();
      hold = 1'b0;
      if (edge_no >= 20 && edge_no <= 30) chk("hold_s0", 32'(st1[0]), 32'(1));
      case (edge_no)
        41: chk("hold_e41", 32'(st1), 32'(3'b001));
        42: chk("hold_e42", 32'(st1), 32'(3'b011));
        57: chk("hold_e57", 32'(st1), 32'(3'b011));
        58: chk("hold_e58", 32'(st1), 32'(3'b111));
        59: chk("hold_e59_rdy", 32'(rdy1), 32'(1));
        default: ;
      endcase
    end

    // soft reset from RUN, with ignored requests during ASSERT and SEQ
    soft_rst_req = 1'b1;
    hold = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    hold = 1'b0;
    e0 = edge_no;
    chk("sr_enter_st", 32'(st1), 32'(0));
    chk("sr_enter_bsy", 32'(busy1), 32'(1));
    repeat (70) begin
      soft_rst_req = (edge_no + 1 == e0 + 2) || (edge_no + 1 == e0 + 10);
      tick();
      soft_rst_req = 1'b0;
      if (edge_no == e0 + 4)  chk("sr_seq_entry", 32'(st1), 32'(0));
      if (edge_no == e0 + 19) chk("sr_e19", 32'(st1), 32'(0));
      if (edge_no == e0 + 20) chk("sr_e20", 32'(st1), 32'(3'b001));
      if (edge_no == e0 + 52) chk("sr_rdy_lo", 32'(rdy1), 32'(0));
      if (edge_no == e0 + 53) chk("sr_rdy_hi", 32'(rdy1), 32'(1));
    end

    // reset pulled mid-sequence at edge 35, then full sequence again
    async_reset(2);
    repeat (35) tick();
    chk("mid_e35", 32'(st1), 32'(3'b011));
    async_reset(2);
    repeat (50) begin
      tick();
      pu_checks();
    end

    // watchdog: regular kicks, then none
    for (int i = 0; i < 400; i++) begin
      wdog_kick = (i % 50 == 0);
      tick();
      wdog_kick = 1'b0;
    end
    chk("wd_kicked_rdy", 32'(rdy1), 32'(1));
    chk("wd_kicked_wdf", 32'(fired1), 32'(0));
    repeat (200) tick();
    chk("wd_starved_wdf", 32'(fired1), 32'(WD_EN));

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      soft_rst_req = ($urandom_range(0, 29) == 0);
      hold         = ($urandom_range(0, 3) == 0);
      wdog_kick    = ($urandom_range(0, 39) == 0);
      tick();
      if ($urandom_range(0, 499) == 0) async_reset($urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "simulation time limit");
  end

endmodule
